// File: rtl/types.sv
// Shared types for the MESI snooping-bus requesters.
// Bus command encoding, CPU count and the requester FSM states.
package types;

    localparam int NUM_CPUS = 4;

    typedef enum logic [1:0] {
        BUS_RD    = 2'd0,
        BUS_RDX   = 2'd1,
        BUS_UPGR  = 2'd2,
        BUS_FLUSH = 2'd3
    } bus_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CMD  = 3'd2,
        ST_RESP = 3'd3,
        ST_DONE = 3'd4
    } bm_state_t;

    // Any encoding outside the known set is issued as a plain read.
    function automatic bus_cmd_t sanitize_cmd(input logic [1:0] c);
        bus_cmd_t r;
        case (c)
            2'd1:    r = BUS_RDX;
            2'd2:    r = BUS_UPGR;
            2'd3:    r = BUS_FLUSH;
            default: r = BUS_RD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cache_bus_master.sv
// Per-cache bus-side requester: arbitrates for the snooping bus,
// issues one command, waits for the response, reports completion.
module cache_bus_master
    import types::*;
#(
    parameter int CPU_ID         = 0,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int WAIT_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_valid,
    output logic                      cpu_ready,
    input  bus_cmd_t                  cpu_cmd,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr,
    input  logic [LINE_WIDTH-1:0]     cpu_wdata,
    output logic                      cpu_done,
    output logic [LINE_WIDTH-1:0]     cpu_rdata,
    output logic                      cpu_shared,
    output logic                      req,
    input  logic                      gnt,
    output logic                      busy,
    output logic                      bus_valid,
    output bus_cmd_t                  bus_cmd,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic [LINE_WIDTH-1:0]     bus_wdata,
    input  logic                      bus_resp_valid,
    input  logic [LINE_WIDTH-1:0]     bus_resp_data,
    input  logic                      bus_resp_shared,
    output logic [WAIT_CNT_WIDTH-1:0] wait_cycles
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX = '1;

    if (CPU_ID < 0 || CPU_ID >= NUM_CPUS) begin : g_bad_cpu_id
        $error("cache_bus_master: CPU_ID out of range");
    end

    bm_state_t                 r_state;
    bus_cmd_t                  r_cmd;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [LINE_WIDTH-1:0]     r_wdata;
    logic [LINE_WIDTH-1:0]     r_rdata;
    logic                      r_shared;
    logic [WAIT_CNT_WIDTH-1:0] r_wait;
    logic                      w_no_resp;

    // Upgrades and flushes carry no data back, so they skip RESP.
    assign w_no_resp = (r_cmd == BUS_UPGR) || (r_cmd == BUS_FLUSH);

    // Transaction FSM with the latched request, wait counter and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cmd    <= BUS_RD;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_shared <= 1'b0;
            r_wait   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cpu_valid) begin
                        r_cmd   <= sanitize_cmd(cpu_cmd);
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_wait  <= '0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (gnt) begin
                        r_state <= ST_CMD;
                    end else if (r_wait != WAIT_MAX) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_CMD: begin
                    r_state <= w_no_resp ? ST_DONE : ST_RESP;
                end
                ST_RESP: begin
                    if (bus_resp_valid) begin
                        r_rdata  <= bus_resp_data;
                        r_shared <= bus_resp_shared;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready   = (r_state == ST_IDLE);
    assign req         = (r_state == ST_REQ);
    assign bus_valid   = (r_state == ST_CMD);
    assign cpu_done    = (r_state == ST_DONE);
    assign busy        = (r_state == ST_CMD) ||
                         (r_state == ST_RESP) ||
                         (r_state == ST_DONE);
    assign bus_cmd     = r_cmd;
    assign bus_addr    = r_addr;
    assign bus_wdata   = r_wdata;
    assign cpu_rdata   = r_rdata;
    assign cpu_shared  = r_shared;
    assign wait_cycles = r_wait;

endmodule

// File: tb/tb_cache_bus_master.sv
// Self-checking bench for cache_bus_master: table vectors, random
// transactions against a latency/data model, and a 4-CPU arbiter run.
`timescale 1ns/1ps
module tb_cache_bus_master;
    import types::*;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int WW = 8;
    localparam int NC = NUM_CPUS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic          cpu_valid, cpu_ready, cpu_done, cpu_shared;
    bus_cmd_t      cpu_cmd, bus_cmd;
    logic [AW-1:0] cpu_addr, bus_addr;
    logic [LW-1:0] cpu_wdata, cpu_rdata, bus_wdata, bus_resp_data;
    logic          req, gnt, busy, bus_valid, bus_resp_valid, bus_resp_shared;
    logic [WW-1:0] wait_cycles;
    logic          gnt_en, gnt_force;

    assign gnt = gnt_force | (req & gnt_en);

    cache_bus_master #(.CPU_ID(0), .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
                       .WAIT_CNT_WIDTH(WW)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_shared(cpu_shared),
        .req(req), .gnt(gnt), .busy(busy), .bus_valid(bus_valid),
        .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
        .bus_resp_shared(bus_resp_shared), .wait_cycles(wait_cycles)
    );

    // ---------------- four requesters on a round-robin arbiter
    logic [NC-1:0] a_valid, a_ready, a_done, a_shared;
    logic [NC-1:0] a_req, a_gnt, a_busy, a_bv, a_rv;
    bus_cmd_t      a_cmd_in;
    logic [AW-1:0] a_addr_in;
    logic [LW-1:0] a_rdat;
    logic          a_rsh;
    logic [LW-1:0] zero_line = '0;
    logic [LW-1:0] a_rdata  [NC];
    bus_cmd_t      a_bcmd   [NC];
    logic [AW-1:0] a_baddr  [NC];
    logic [LW-1:0] a_bwdata [NC];
    logic [WW-1:0] a_wait   [NC];
    int            rr_last = NC - 1;

    always_comb begin
        a_gnt = '0;
        if (a_busy == '0) begin
            for (int o = 1; o <= NC; o++) begin
                if (a_req[(rr_last + o) % NC] && a_gnt == '0)
                    a_gnt[(rr_last + o) % NC] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++)
            if (a_req[i] && a_gnt[i]) rr_last <= i;
    end

    for (genvar g = 0; g < NC; g++) begin : g_cpu
        cache_bus_master #(.CPU_ID(g), .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
                           .WAIT_CNT_WIDTH(WW)) u_m (
            .clk(clk), .rst(rst),
            .cpu_valid(a_valid[g]), .cpu_ready(a_ready[g]),
            .cpu_cmd(a_cmd_in), .cpu_addr(a_addr_in + AW'(g)),
            .cpu_wdata(zero_line),
            .cpu_done(a_done[g]), .cpu_rdata(a_rdata[g]),
            .cpu_shared(a_shared[g]),
            .req(a_req[g]), .gnt(a_gnt[g]), .busy(a_busy[g]),
            .bus_valid(a_bv[g]), .bus_cmd(a_bcmd[g]), .bus_addr(a_baddr[g]),
            .bus_wdata(a_bwdata[g]),
            .bus_resp_valid(a_rv[g]), .bus_resp_data(a_rdat),
            .bus_resp_shared(a_rsh), .wait_cycles(a_wait[g])
        );
    end

    // ---------------- checking helpers
    task automatic chk(input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int j = 0; j < LW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [LW-1:0] cpu_line(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {(LW/32){w}};
    endfunction

    // Reference model: data/shared seen by the cache controller.
    logic [LW-1:0] m_rdata;
    logic          m_shared;

    // Observations of the last transaction.
    int            t_lat, t_busy, t_req, t_bv;
    bus_cmd_t      t_bc;
    logic [AW-1:0] t_ba;
    logic [LW-1:0] t_bw;
    logic          t_gap, t_timeout;

    // Issue one transaction from a negedge in IDLE; grant after gd
    // REQ cycles, response rd cycles after CMD, optional junk responses
    // during REQ. Returns at the negedge of the cpu_done cycle.
    task automatic run_txn(input bus_cmd_t c, input logic [AW-1:0] a,
                           input logic [LW-1:0] wd, input int gd,
                           input int rd, input logic [LW-1:0] rdat,
                           input logic sh, input logic junk);
        int since;
        bit seen_cmd, seen_busy, busy_end;
        since = 0; seen_cmd = 0; seen_busy = 0; busy_end = 0;
        t_lat = -1; t_busy = 0; t_req = 0; t_bv = 0;
        t_gap = 1'b0; t_timeout = 1'b1;
        gnt_en = 1'b0;
        cpu_valid = 1'b1; cpu_cmd = c; cpu_addr = a; cpu_wdata = wd;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            cpu_valid = 1'b0;
            bus_resp_valid = 1'b0;
            if (req) t_req++;
            if (busy) begin
                t_busy++;
                if (busy_end) t_gap = 1'b1;
                seen_busy = 1;
            end else if (seen_busy) begin
                busy_end = 1;
            end
            if (bus_valid) begin
                t_bv++; t_bc = bus_cmd; t_ba = bus_addr; t_bw = bus_wdata;
                seen_cmd = 1;
            end else if (seen_cmd) begin
                since++;
            end
            gnt_en = (t_req > gd);
            if (seen_cmd && since == rd) begin
                bus_resp_valid = 1'b1;
                bus_resp_data = rdat; bus_resp_shared = sh;
            end else if (junk && req) begin
                bus_resp_valid = 1'b1;
                bus_resp_data = ~rdat; bus_resp_shared = ~sh;
            end
            if (cpu_done) begin
                t_lat = k; t_timeout = 1'b0;
                break;
            end
        end
        bus_resp_valid = 1'b0;
        gnt_en = 1'b0;
    endtask

    task automatic post_check(input string tag, input bus_cmd_t c,
                              input logic [AW-1:0] a,
                              input logic [LW-1:0] wd, input int gd,
                              input int e_wait, input int e_lat,
                              input int e_busy);
        chk({tag, " timeout"}, t_timeout, 1'b0);
        chk({tag, " done latency"}, t_lat, e_lat);
        chk({tag, " busy cycles"}, t_busy, e_busy);
        chk({tag, " busy gap"}, t_gap, 1'b0);
        chk({tag, " req cycles"}, t_req, gd + 1);
        chk({tag, " bus_valid cycles"}, t_bv, 1);
        chk({tag, " bus_cmd"}, t_bc, c);
        chk({tag, " bus_addr"}, t_ba, a);
        if (c == BUS_FLUSH) chk({tag, " bus_wdata"}, t_bw, wd);
        chk({tag, " wait_cycles"}, wait_cycles, e_wait);
        chk({tag, " cpu_rdata"}, cpu_rdata, m_rdata);
        chk({tag, " cpu_shared"}, cpu_shared, m_shared);
        @(negedge clk);
        chk({tag, " done one pulse"}, cpu_done, 1'b0);
        chk({tag, " ready after"}, cpu_ready, 1'b1);
        chk({tag, " busy after"}, busy, 1'b0);
    endtask

    typedef struct {
        bus_cmd_t      c;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        int            gd;
        int            rd;
        logic [LW-1:0] rdat;
        logic          sh;
        int            e_wait;
        int            e_lat;
        int            e_busy;
    } vec_t;

    vec_t vt[5];

    initial begin
        bus_cmd_t      rc;
        logic [AW-1:0] ra;
        logic [LW-1:0] rw, rdat;
        int            gd, rd, pend[NC], order[$], ndone;
        logic          sh, junk, overlap;
        bit            rdcmd;

        vt[0] = '{BUS_UPGR, 32'h0000_1000, {LW{1'b0}}, 0, 1,
                  {LW{1'b0}}, 1'b0, 0, 3, 2};
        vt[1] = '{BUS_RD, 32'h0000_2040, {LW{1'b0}}, 5, 4,
                  {(LW/8){8'hA5}}, 1'b1, 5, 12, 6};
        vt[2] = '{BUS_FLUSH, 32'h0000_3000, {(LW/32){32'hDEAD_BEEF}}, 2, 1,
                  {LW{1'b0}}, 1'b0, 2, 5, 2};
        vt[3] = '{BUS_RDX, 32'h0000_4000, {LW{1'b0}}, 300, 1,
                  {(LW/32){32'h0123_4567}}, 1'b0, 255, 304, 3};
        vt[4] = '{BUS_RD, 32'h0000_5000, {LW{1'b0}}, 0, 1,
                  {(LW/16){16'h5AC3}}, 1'b0, 0, 4, 3};

        cpu_valid = 1'b0; cpu_cmd = BUS_RD; cpu_addr = '0; cpu_wdata = '0;
        gnt_en = 1'b0; gnt_force = 1'b0;
        bus_resp_valid = 1'b0; bus_resp_data = '0; bus_resp_shared = 1'b0;
        a_valid = '0; a_rv = '0; a_cmd_in = BUS_RD; a_addr_in = '0;
        a_rdat = '0; a_rsh = 1'b0;
        m_rdata = '0; m_shared = 1'b0;

        repeat (3) @(negedge clk);
        chk("in reset busy", busy, 1'b0);
        chk("in reset req", req, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset cpu_ready", cpu_ready, 1'b1);
        chk("reset req", req, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset bus_valid", bus_valid, 1'b0);
        chk("reset cpu_done", cpu_done, 1'b0);
        chk("reset wait_cycles", wait_cycles, 0);
        chk("reset cpu_rdata", cpu_rdata, 0);
        chk("reset cpu_shared", cpu_shared, 1'b0);

        // Grant with no request must not start anything.
        gnt_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray gnt bus_valid", bus_valid, 1'b0);
            chk("stray gnt busy", busy, 1'b0);
        end
        gnt_force = 1'b0;

        // Table vectors.
        for (int i = 0; i < 5; i++) begin
            run_txn(vt[i].c, vt[i].a, vt[i].wd, vt[i].gd, vt[i].rd,
                    vt[i].rdat, vt[i].sh, 1'b0);
            if (vt[i].c == BUS_RD || vt[i].c == BUS_RDX) begin
                m_rdata = vt[i].rdat; m_shared = vt[i].sh;
            end
            post_check($sformatf("vec%0d", i), vt[i].c, vt[i].a, vt[i].wd,
                       vt[i].gd, vt[i].e_wait, vt[i].e_lat, vt[i].e_busy);
            if (i == 2) begin
                bus_resp_valid = 1'b1; bus_resp_data = ~m_rdata;
                bus_resp_shared = ~m_shared;
                repeat (2) begin
                    @(negedge clk);
                    chk("spurious resp done", cpu_done, 1'b0);
                    chk("spurious resp ready", cpu_ready, 1'b1);
                end
                bus_resp_valid = 1'b0;
                @(negedge clk);
                chk("spurious resp rdata", cpu_rdata, m_rdata);
                chk("spurious resp shared", cpu_shared, m_shared);
            end
        end

        // Reset while waiting for a response.
        cpu_valid = 1'b1; cpu_cmd = BUS_RD; cpu_addr = 32'h7000;
        @(negedge clk);
        cpu_valid = 1'b0; gnt_en = 1'b1;
        @(negedge clk);
        gnt_en = 1'b0;
        chk("rst seq cmd", bus_valid, 1'b1);
        @(negedge clk);
        chk("rst seq in resp busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst async busy", busy, 1'b0);
        chk("rst async ready", cpu_ready, 1'b1);
        chk("rst async rdata", cpu_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        m_rdata = '0; m_shared = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_data = {(LW/32){32'hBAD0_BAD0}};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus_resp_valid = 1'b0;
            chk("after rst no done", cpu_done, 1'b0);
        end
        chk("after rst rdata", cpu_rdata, m_rdata);
        rdat = rnd_line();
        run_txn(BUS_RD, 32'h7040, '0, 1, 2, rdat, 1'b1, 1'b0);
        m_rdata = rdat; m_shared = 1'b1;
        post_check("post rst RD", BUS_RD, 32'h7040, '0, 1, 1, 6, 4);

        // Random transactions against the latency/data model.
        for (int n = 0; n < 40; n++) begin
            rc   = bus_cmd_t'($urandom_range(0, 3));
            ra   = $urandom;
            rw   = rnd_line();
            rdat = rnd_line();
            gd   = $urandom_range(0, 6);
            rd   = $urandom_range(1, 5);
            sh   = 1'($urandom_range(0, 1));
            junk = 1'($urandom_range(0, 1));
            rdcmd = (rc == BUS_RD) || (rc == BUS_RDX);
            run_txn(rc, ra, rw, gd, rd, rdat, sh, junk);
            if (rdcmd) begin
                m_rdata = rdat; m_shared = sh;
            end
            post_check($sformatf("rnd%0d", n), rc, ra, rw, gd,
                       (gd > 255) ? 255 : gd,
                       rdcmd ? gd + rd + 3 : gd + 3,
                       rdcmd ? rd + 2 : 2);
        end

        // Four requesters contending for the bus.
        foreach (pend[i]) pend[i] = 0;
        overlap = 1'b0; ndone = 0;
        a_cmd_in = BUS_RD; a_addr_in = 32'h8000; a_valid = '1;
        for (int k = 0; k < 300 && ndone < NC; k++) begin
            @(negedge clk);
            a_valid = '0; a_rv = '0;
            if ($countones(a_busy) > 1) overlap = 1'b1;
            for (int i = 0; i < NC; i++) begin
                if (a_bv[i] && ((a_busy & ~(NC'(1) << i)) != '0))
                    overlap = 1'b1;
                if (a_done[i]) ndone++;
                if (a_bv[i]) begin
                    order.push_back(i);
                    pend[i] = 2;
                end else if (pend[i] > 0) begin
                    pend[i]--;
                    if (pend[i] == 0) begin
                        a_rv[i] = 1'b1;
                        a_rdat = cpu_line(i);
                        a_rsh = (i % 2) == 1;
                    end
                end
            end
        end
        a_rv = '0;
        chk("multi all done", ndone, NC);
        chk("multi busy overlap", overlap, 1'b0);
        chk("multi grant count", order.size(), NC);
        for (int i = 0; i < NC; i++) begin
            if (i < order.size())
                chk($sformatf("multi order %0d", i), order[i], i);
            chk($sformatf("multi rdata %0d", i), a_rdata[i], cpu_line(i));
            chk($sformatf("multi shared %0d", i), a_shared[i], (i % 2) == 1);
            chk($sformatf("multi addr %0d", i), a_baddr[i], 32'h8000 + i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
